// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding decisions for a five-stage MIPS pipeline.
// Tracks E/M/W destinations with result timing, plus a multiply/divide busy counter.
module hazard_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instr,
    input  logic        D_judge,
    output logic        stall,
    output logic [1:0]  D_fwd_rs,
    output logic [1:0]  D_fwd_rt,
    output logic [1:0]  E_fwd_rs,
    output logic [1:0]  E_fwd_rt,
    output logic        mdu_start,
    output logic        mdu_busy
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1a;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;

    localparam logic [4:0] RT_BGEZAL = 5'h11;
    localparam logic [4:0] REG_RA    = 5'd31;

    localparam logic [1:0] FWD_D_GRF  = 2'd0;
    localparam logic [1:0] FWD_D_EPC8 = 2'd1;
    localparam logic [1:0] FWD_D_MRES = 2'd2;
    localparam logic [1:0] FWD_E_REG  = 2'd0;
    localparam logic [1:0] FWD_E_MRES = 2'd1;
    localparam logic [1:0] FWD_E_WRES = 2'd2;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

    // rs/rt hold only the registers the instruction actually reads (0 otherwise)
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       is_muldiv;
        logic       is_div;
    } e_entry_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_entry_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] f_rs;
    logic [4:0] f_rt;
    logic [4:0] f_rd;
    logic [4:0] shamt;

    assign op    = D_instr[31:26];
    assign f_rs  = D_instr[25:21];
    assign f_rt  = D_instr[20:16];
    assign f_rd  = D_instr[15:11];
    assign shamt = D_instr[10:6];
    assign funct = D_instr[5:0];

    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       d_hilo;
    e_entry_t   d_entry;

    e_entry_t         e_q;
    m_entry_t         m_q;
    m_entry_t         m_next;
    logic [4:0]       w_dst_q;
    logic [CNT_W-1:0] busy_cnt;

    logic stall_data;
    logic stall_mdu;

    // R-type with a non-zero shamt field is not in the decoded set and falls to nop
    always_comb begin
        d_rs    = '0;
        d_rt    = '0;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
        d_hilo  = 1'b0;
        d_entry = '0;
        case (op)
            OP_RTYPE: begin
                if (shamt == 5'd0) begin
                    case (funct)
                        FN_ADD, FN_SUB: begin
                            d_rs         = f_rs;
                            d_rt         = f_rt;
                            tuse_rs      = 2'd1;
                            tuse_rt      = 2'd1;
                            d_entry.dst  = f_rd;
                            d_entry.tnew = 2'd1;
                        end
                        FN_JR: begin
                            d_rs    = f_rs;
                            tuse_rs = 2'd0;
                        end
                        FN_MULT, FN_DIV: begin
                            d_rs              = f_rs;
                            d_rt              = f_rt;
                            tuse_rs           = 2'd1;
                            tuse_rt           = 2'd1;
                            d_hilo            = 1'b1;
                            d_entry.is_muldiv = 1'b1;
                            d_entry.is_div    = (funct == FN_DIV);
                        end
                        FN_MFHI, FN_MFLO: begin
                            d_hilo       = 1'b1;
                            d_entry.dst  = f_rd;
                            d_entry.tnew = 2'd1;
                        end
                        FN_MTHI, FN_MTLO: begin
                            d_rs    = f_rs;
                            tuse_rs = 2'd1;
                            d_hilo  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            OP_REGIMM: begin
                if (f_rt == RT_BGEZAL) begin
                    d_rs         = f_rs;
                    tuse_rs      = 2'd0;
                    d_entry.dst  = D_judge ? REG_RA : 5'd0;
                    d_entry.tnew = 2'd0;
                end
            end
            OP_JAL: begin
                d_entry.dst  = REG_RA;
                d_entry.tnew = 2'd0;
            end
            OP_J: ;
            OP_BEQ: begin
                d_rs    = f_rs;
                d_rt    = f_rt;
                tuse_rs = 2'd0;
                tuse_rt = 2'd0;
            end
            OP_ORI: begin
                d_rs         = f_rs;
                tuse_rs      = 2'd1;
                d_entry.dst  = f_rt;
                d_entry.tnew = 2'd1;
            end
            OP_LUI: begin
                d_entry.dst  = f_rt;
                d_entry.tnew = 2'd1;
            end
            OP_LW: begin
                d_rs         = f_rs;
                tuse_rs      = 2'd1;
                d_entry.dst  = f_rt;
                d_entry.tnew = 2'd2;
            end
            OP_SW: begin
                d_rs    = f_rs;
                d_rt    = f_rt;
                tuse_rs = 2'd1;
                tuse_rt = 2'd2;
            end
            default: ;
        endcase
        d_entry.rs = d_rs;
        d_entry.rt = d_rt;
    end

    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input e_entry_t e, input m_entry_t m);
        return (src != 5'd0) &&
               (((e.dst == src) && (e.tnew > tuse)) ||
                ((m.dst == src) && (m.tnew > tuse)));
    endfunction

    function automatic logic [1:0] d_sel(input logic [4:0] src,
                                         input e_entry_t e, input m_entry_t m);
        if (src == 5'd0)
            return FWD_D_GRF;
        if ((e.dst == src) && (e.tnew == 2'd0))
            return FWD_D_EPC8;
        if ((m.dst == src) && (m.tnew == 2'd0))
            return FWD_D_MRES;
        return FWD_D_GRF;
    endfunction

    // nearer stage first: M beats W
    function automatic logic [1:0] e_sel(input logic [4:0] src,
                                         input m_entry_t m, input logic [4:0] w_dst);
        if (src == 5'd0)
            return FWD_E_REG;
        if ((m.dst == src) && (m.tnew == 2'd0))
            return FWD_E_MRES;
        if (w_dst == src)
            return FWD_E_WRES;
        return FWD_E_REG;
    endfunction

    assign stall_data = src_stall(d_rs, tuse_rs, e_q, m_q) |
                        src_stall(d_rt, tuse_rt, e_q, m_q);
    assign stall_mdu  = d_hilo && (mdu_start || mdu_busy);
    assign stall      = stall_data || stall_mdu;

    assign D_fwd_rs  = d_sel(d_rs, e_q, m_q);
    assign D_fwd_rt  = d_sel(d_rt, e_q, m_q);
    assign E_fwd_rs  = e_sel(e_q.rs, m_q, w_dst_q);
    assign E_fwd_rt  = e_sel(e_q.rt, m_q, w_dst_q);
    assign mdu_start = e_q.is_muldiv;
    assign mdu_busy  = (busy_cnt != '0);

    always_comb begin
        m_next.dst  = e_q.dst;
        m_next.tnew = (e_q.tnew == 2'd0) ? 2'd0 : (e_q.tnew - 2'd1);
    end

    // a mult/div cannot reach E while busy, so load and decrement never collide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_dst_q  <= '0;
            busy_cnt <= '0;
        end else begin
            w_dst_q <= m_q.dst;
            m_q     <= m_next;
            e_q     <= stall ? '0 : d_entry;
            if (e_q.is_muldiv)
                busy_cnt <= e_q.is_div ? DIV_LOAD : MUL_LOAD;
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline, extending the single-cycle decode of the main controller with stage tracking. It decodes the D-stage instruction into register-use and register-write timing (Tuse/Tnew) and keeps an internal scoreboard of the E, M and W stages. It also owns a multi-cycle MDU busy counter. It drives the global stall, the D/E forwarding selects and the MDU start pulse.

## Interface
- MUL_LAT, 5, cycles the MDU stays busy after a mult starts (1..2^CNT_W-1)
- DIV_LAT, 10, cycles the MDU stays busy after a div starts (1..2^CNT_W-1)
- CNT_W, 4, width of the busy counter
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- D_instr  input  32  instruction word held in the F/D register
- D_judge  input  1  bgezal condition (rs >= 0) from the D-stage comparator
- stall  output  1  freeze PC and F/D, insert a bubble into D/E
- D_fwd_rs, D_fwd_rt  output  2  D-stage operand source: 0 GRF, 1 E-stage PC+8, 2 M-stage result
- E_fwd_rs, E_fwd_rt  output  2  E-stage operand source: 0 D/E register, 1 M result, 2 W result
- mdu_start  output  1  high while a mult/div sits in E
- mdu_busy  output  1  busy counter non-zero

## Operation
- Decoded set: add, sub, ori, lw, sw, beq, lui, jal, jr, j, bgezal, mult, div, mfhi, mflo, mthi, mtlo. Unknown opcodes decode as nop: no sources, dst 0.
- Tuse is the number of cycles after D at which an operand is needed.
  - Tuse 0: beq rs/rt, jr rs, bgezal rs.
  - Tuse 1: add/sub rs/rt; ori/lw/sw rs; mult/div rs/rt; mthi/mtlo rs.
  - Tuse 2: sw rt.
- Destination register:
  - rd for add/sub/mfhi/mflo.
  - rt for ori/lw/lui.
  - 31 for jal.
  - 31 for bgezal only when D_judge=1, else 0.
  - Destination 0 means no write.
- Tnew at entry to E:
  - 0 for jal/bgezal (PC+8 is available in E).
  - 1 for add/sub/ori/lui/mfhi/mflo.
  - 2 for lw.
- Scoreboard entries {rs, rt, dst, tnew, is_muldiv} exist for E, M and W.
- On each edge:
  - W takes M.
  - M takes E with tnew decremented, saturating at 0.
  - E takes the decoded D instruction, or a bubble (all fields 0) when stall=1.
- Data stall: for each source s of D with s != 0, stall if E.dst==s and E.tnew > Tuse(s), or if M.dst==s and M.tnew > Tuse(s).
- MDU stall: D is mfhi/mflo/mthi/mtlo/mult/div and (mdu_start or mdu_busy).
- stall = data stall OR MDU stall. It is combinational from D_instr, D_judge and registered state.
- D forwarding, rs and rt independently:
  - 1 if E.dst==src!=0 and E.tnew==0.
  - Otherwise 2 if M.dst==src!=0 and M.tnew==0.
  - Otherwise 0.
  - The W-stage write-through is handled inside the GRF.
- E forwarding, using E.rs/E.rt:
  - 1 if M.dst matches and M.tnew==0.
  - Otherwise 2 if W.dst matches.
  - Otherwise 0.
  - The nearer stage always wins.
- Busy counter:
  - On an edge with E.is_muldiv set, load MUL_LAT for mult or DIV_LAT for div.
  - Otherwise decrement while non-zero.
- mdu_start = E.is_muldiv. mdu_busy = (counter != 0).

## Timing
- All outputs are combinational from registered state plus the D inputs; zero-cycle decision.
- Reset values:
  - stall=0, all fwd selects 0, mdu_start=0, mdu_busy=0.
  - All scoreboard entries are bubbles; counter=0.
- A stall lasts until the condition clears. Each stalled cycle inserts exactly one bubble.
- A mult held in E for one cycle produces exactly one mdu_start cycle. busy is then high for exactly MUL_LAT cycles (DIV_LAT for div).
- Simultaneous load and decrement cannot occur. A new mult/div cannot enter E while busy, because it is stalled in D.
- Reset asserted mid-busy clears the counter immediately and drops stall in the same cycle. No stale E/M entries survive.
- Register $0 never causes a stall or a forward.

## Test plan
- lw $1 in E, add $2,$1,$3 in D -> stall=1 for exactly one cycle. Next cycle stall=0. The cycle after, add is in E with E_fwd_rs=2.
- add $1 in E, beq $1,$0 in D -> one stall cycle, then D_fwd_rs=2 (M) with no stall.
- jal in E, jr $31 in D -> no stall, D_fwd_rs=1.
- bgezal in D with D_judge=0, then add $4,$31,$31 -> no stall, all fwd selects 0. Repeat with D_judge=1 -> E_fwd_rs/E_fwd_rt select M on the cycle add reaches E.
- mult then mflo back-to-back, MUL_LAT=5 -> mdu_start high 1 cycle, mdu_busy high 5 cycles, mflo stalled 6 cycles total. With div and DIV_LAT=10 -> 11 stall cycles.
- Assert reset during cycle 3 of a div busy period -> mdu_busy=0 and stall=0 immediately. After release, a new mult starts cleanly and busy lasts MUL_LAT cycles.
